// File: rtl/l1_pkg.sv
// rtl/l1_pkg.sv - shared geometry and FSM encoding for the L1 line adapter
package l1_pkg;
   localparam int LINE_W   = 256;
   localparam int BURST_W  = 64;
   localparam int BEATS    = 4;
   localparam int OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/l1_line_adapter.sv
// rtl/l1_line_adapter.sv - converts L1 line fill/writeback requests into 4-beat memory bursts
module l1_line_adapter
   import l1_pkg::*;
#(
   parameter int LINE_W  = l1_pkg::LINE_W,
   parameter int BURST_W = l1_pkg::BURST_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   output logic               resp_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   output logic [BURST_W-1:0] burst_o,
   input  logic [BURST_W-1:0] burst_i,
   input  logic               resp_i
);

   localparam int IDX_W = $clog2(LINE_W);

   state_t            state;
   state_t            next_state;
   logic [1:0]        beat;
   logic [LINE_W-1:0] buffer;
   logic [IDX_W-1:0]  base;
   logic              last_beat;
   logic              unused_offset;

   always_comb begin
      next_state    = state;
      read_o        = 1'b0;
      write_o       = 1'b0;
      resp_o        = 1'b0;
      burst_o       = '0;
      line_o        = buffer;
      base          = IDX_W'(beat) * IDX_W'(BURST_W);
      last_beat     = resp_i && (beat == 2'(BEATS - 1));
      // Byte offset within the line is dropped when the address is aligned.
      unused_offset = ^address_i[OFFSET_W-1:0];
      case (state)
         IDLE: begin
            if (write_i)
               next_state = WRITE;
            else if (read_i)
               next_state = READ;
         end
         READ: begin
            read_o = 1'b1;
            if (last_beat)
               next_state = DONE;
         end
         WRITE: begin
            write_o = 1'b1;
            burst_o = buffer[base +: BURST_W];
            if (last_beat)
               next_state = DONE;
         end
         DONE: begin
            resp_o     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat      <= 2'd0;
         buffer    <= '0;
         address_o <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (write_i || read_i) begin
                  address_o <= {address_i[31:OFFSET_W], OFFSET_W'(0)};
                  beat      <= 2'd0;
                  if (write_i)
                     buffer <= line_i;
               end
            end
            READ: begin
               if (resp_i) begin
                  buffer[base +: BURST_W] <= burst_i;
                  beat                    <= beat + 2'd1;
               end
            end
            WRITE: begin
               if (resp_i)
                  beat <= beat + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_line_adapter.sv
// tb/tb_l1_line_adapter.sv - randomized scoreboard bench for l1_line_adapter
module tb_l1_line_adapter;
   localparam int LW = 256;
   localparam int BW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   address_i;
   logic          read_i;
   logic          write_i;
   logic [LW-1:0] line_i;
   logic [LW-1:0] line_o;
   logic          resp_o;
   logic [31:0]   address_o;
   logic          read_o;
   logic          write_o;
   logic [BW-1:0] burst_o;
   logic [BW-1:0] burst_i;
   logic          resp_i;

   always #5 clk = ~clk;

   l1_line_adapter #(.LINE_W(LW), .BURST_W(BW)) dut (
      .clk(clk), .rst_n(rst_n), .address_i(address_i), .read_i(read_i),
      .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
      .address_o(address_o), .read_o(read_o), .write_o(write_o),
      .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
   );

   typedef struct {
      logic [31:0]   addr;
      logic [LW-1:0] line;
   } resp_t;

   resp_t         exp_resp_q[$];
   logic [BW-1:0] exp_beat_q[$];
   resp_t         mon_r;
   int            phase;       // expected activity: 0 idle, 1 fill, 2 writeback, 3 completion
   logic [31:0]   model_addr;
   logic [LW-1:0] model_line;
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [BW-1:0] rand_beat();
      return {$urandom, $urandom};
   endfunction

   always @(negedge clk) begin
      chk("read_o", read_o, phase == 1);
      chk("write_o", write_o, phase == 2);
      chk("resp_o", resp_o, phase == 3);
      if (phase == 2) begin
         if (exp_beat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL burst_o: write active with no expected beat left, got %h", burst_o);
         end else begin
            chk("burst_o beat", burst_o, exp_beat_q[0]);
            if (resp_i) void'(exp_beat_q.pop_front());
         end
      end else begin
         chk("burst_o quiet", burst_o, '0);
      end
      if (phase == 0 || phase == 3) chk("line_o held", line_o, model_line);
      if (phase != 0) chk("address_o", address_o, model_addr);
      if (resp_o) begin
         if (exp_resp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_o: got unexpected completion, expected none");
         end else begin
            mon_r = exp_resp_q.pop_front();
            chk("resp address_o", address_o, mon_r.addr);
            chk("resp line_o", line_o, mon_r.line);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, " read_o"}, read_o, 0);
      chk({tag, " write_o"}, write_o, 0);
      chk({tag, " resp_o"}, resp_o, 0);
      chk({tag, " line_o"}, line_o, '0);
      chk({tag, " address_o"}, address_o, 0);
      chk({tag, " burst_o"}, burst_o, '0);
   endtask

   task automatic reset_mid();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid reset");
      void'(exp_resp_q.pop_back());
      exp_beat_q.delete();
      phase      = 0;
      model_line = '0;
      read_i     = 1'b0;
      write_i    = 1'b0;
      resp_i     = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // One L1 transaction; stalls holds a 4-bit idle count before each beat.
   task automatic txn(input bit do_write, input bit do_read, input logic [31:0] addr,
                      input logic [LW-1:0] data, input logic [15:0] stalls,
                      input bit junk, input int abort_at);
      resp_t r;
      address_i = addr;
      read_i    = do_read;
      write_i   = do_write;
      line_i    = do_write ? data : rand_line();
      r.addr    = {addr[31:5], 5'b0};
      r.line    = data;
      exp_resp_q.push_back(r);
      if (do_write)
         for (int k = 0; k < 4; k++) exp_beat_q.push_back(data[k*BW +: BW]);
      @(posedge clk); #1;
      read_i     = 1'b0;
      write_i    = 1'b0;
      resp_i     = 1'b0;
      phase      = do_write ? 2 : 1;
      model_addr = r.addr;
      for (int k = 0; k < 4; k++) begin
         if (k == abort_at) begin
            reset_mid();
            return;
         end
         repeat (stalls[k*4 +: 4]) begin
            resp_i  = 1'b0;
            burst_i = rand_beat();
            if (junk) begin
               read_i    = 1'($urandom);
               write_i   = 1'($urandom);
               address_i = $urandom;
               line_i    = rand_line();
            end
            @(posedge clk); #1;
         end
         resp_i  = 1'b1;
         burst_i = do_write ? rand_beat() : data[k*BW +: BW];
         @(posedge clk); #1;
      end
      resp_i     = 1'($urandom);
      burst_i    = rand_beat();
      read_i     = 1'b0;
      write_i    = 1'b0;
      phase      = 3;
      model_line = data;
      chk("resp_o after last beat", resp_o, 1);
      @(posedge clk); #1;
      resp_i = 1'b0;
      phase  = 0;
   endtask

   task automatic idle_spurious(input int n);
      repeat (n) begin
         resp_i  = 1'b1;
         burst_i = rand_beat();
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
   endtask

   initial begin
      logic [LW-1:0] d;
      bit            w;
      rst_n      = 1'b1;
      read_i     = 1'b0;
      write_i    = 1'b0;
      resp_i     = 1'b0;
      address_i  = '0;
      line_i     = '0;
      burst_i    = '0;
      phase      = 0;
      model_line = '0;
      model_addr = '0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      d = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
      txn(1'b0, 1'b1, 32'h0000_1234, d, 16'h0000, 1'b0, 4);
      chk("fill aligned address", address_o, 32'h0000_1220);

      txn(1'b1, 1'b0, $urandom, {64'hD, 64'hC, 64'hB, 64'hA}, 16'h0000, 1'b0, 4);
      txn(1'b0, 1'b1, $urandom, rand_line(), 16'h0300, 1'b0, 4);
      txn(1'b1, 1'b1, $urandom, rand_line(), 16'h0101, 1'b0, 4);
      txn(1'b0, 1'b1, $urandom, rand_line(), 16'h0000, 1'b0, 2);
      txn(1'b0, 1'b1, $urandom, rand_line(), 16'h0000, 1'b0, 4);
      idle_spurious(4);
      txn(1'b1, 1'b0, $urandom, rand_line(), 16'h1212, 1'b1, 4);
      idle_spurious(2);

      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom);
         txn(w, w ? 1'($urandom) : 1'b1, $urandom, rand_line(),
             16'($urandom) & 16'h3333, 1'($urandom),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : 4);
         idle_spurious($urandom_range(0, 2));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("completion queue drained", exp_resp_q.size(), 0);
      chk("write beat queue drained", exp_beat_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/l1_line_adapter.md
L1_LINE_ADAPTER -- requirements
Module: l1_line_adapter

Interface
REQ-001 Parameter LINE_W, 256, cache line width in bits; SHALL equal BURST_W*4.
REQ-002 Parameter BURST_W, 64, memory beat width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 address_i  input  32  L1 request byte address.
REQ-006 read_i  input  1  L1 line-fill request.
REQ-007 write_i  input  1  L1 line-writeback request.
REQ-008 line_i  input  LINE_W  writeback line from L1 data array.
REQ-009 line_o  output  LINE_W  filled line toward L1 data array datain.
REQ-010 resp_o  output  1  one-cycle completion pulse to L1.
REQ-011 address_o  output  32  line-aligned memory address.
REQ-012 read_o  output  1  memory burst-read request.
REQ-013 write_o  output  1  memory burst-write request.
REQ-014 burst_o  output  BURST_W  write beat data.
REQ-015 burst_i  input  BURST_W  read beat data.
REQ-016 resp_i  input  1  memory beat-accept/valid strobe.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, DONE; 2-bit beat counter.
REQ-018 IDLE: write_i=1 -> WRITE; else read_i=1 -> READ; write SHALL win when both asserted (writeback before fill).
REQ-019 On leaving IDLE, address_o SHALL latch {address_i[31:5],5'b0}; line_i SHALL latch into line buffer on a write; beat counter cleared.
REQ-020 read_i/write_i/address_i/line_i SHALL be ignored outside IDLE.
REQ-021 READ: read_o=1; each cycle resp_i=1, burst_i SHALL be stored at buffer bits [BURST_W*beat +: BURST_W] and beat increments.
REQ-022 WRITE: write_o=1; burst_o SHALL equal buffer[BURST_W*beat +: BURST_W]; beat increments on resp_i=1.
REQ-023 Beat 3 accepted (resp_i=1, beat=3) -> DONE; read_o/write_o SHALL be 0 in DONE.
REQ-024 DONE: resp_o=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 resp_i=0 SHALL stall the current beat indefinitely with all outputs held.
REQ-026 line_o SHALL drive the line buffer continuously; valid for fill in DONE cycle and held until next transaction loads buffer.
REQ-027 Minimum latency: request seen cycle 0, read_o/write_o from cycle 1, resp_i every cycle 1-4 -> resp_o in cycle 5.
REQ-028 resp_i asserted in IDLE or DONE SHALL be ignored.
REQ-029 burst_o SHALL be 0 outside WRITE.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, beat=0, buffer=0, address_o=0, read_o=write_o=resp_o=0, line_o=0, burst_o=0.
REQ-031 Reset mid-transaction SHALL abandon it with no resp_o; first post-reset request SHALL start a fresh 4-beat burst.

Structure
REQ-032 Shared package l1_pkg SHALL hold LINE_W/BURST_W defaults, BEATS=4, line-offset width 5, and the FSM state enum.
REQ-033 No sub-module; single module with one sequential block and one combinational output block.

Verification
REQ-034 Fill: read_i, address_i=0x0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 resp_i back-to-back -> address_o=0x0000_1220, resp_o in cycle 5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-035 Writeback: write_i, line_i={64'hD,64'hC,64'hB,64'hA} -> burst_o sequence A,B,C,D with write_o=1, resp_o one cycle after 4th resp_i.
REQ-036 Stall: fill with resp_i=0 for 3 cycles between beats 1 and 2 -> burst ordering intact, read_o held, resp_o only after beat 3.
REQ-037 Simultaneous read_i=write_i=1 -> write_o asserted, read_o stays 0 for whole burst.
REQ-038 rst_n pulled low after beat 2 of a fill -> outputs zero immediately, no resp_o; next fill completes normally with correct data.
REQ-039 Spurious resp_i in IDLE and read_i toggled mid-WRITE -> no state change, no extra resp_o.
